// File: rtl/multi_port_lutram_clr.sv
// Multi-read-port, single-write-port distributed RAM with byte strobes, registered reads
// and a clear sequencer. Define LUTRAM_WR_BYPASS_EN to forward same-cycle writes to reads.
module multi_port_lutram_clr #(
    parameter int DATA_WIDTH      = 128,
    parameter int DATA_DEPTH_EXP2 = 8,
    parameter int ADDR_WIDTH      = DATA_DEPTH_EXP2,
    parameter int NUM_RD_PORTS    = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    output logic                               ready_o,
    input  logic                               we_i,
    input  logic [DATA_WIDTH/8-1:0]            wstrb_i,
    input  logic [ADDR_WIDTH-1:0]              waddr_i,
    input  logic [DATA_WIDTH-1:0]              wdata_i,
    input  logic [NUM_RD_PORTS-1:0]            re_i,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rdata_o
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** DATA_DEPTH_EXP2;
    localparam logic [DATA_DEPTH_EXP2-1:0] CNT_LAST = '1;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (NUM_RD_PORTS < 1) begin : g_bad_ports
        $error("NUM_RD_PORTS must be at least 1");
    end
    if (ADDR_WIDTH < DATA_DEPTH_EXP2) begin : g_bad_addr
        $error("ADDR_WIDTH must cover DATA_DEPTH_EXP2 bits");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e                     state_q, state_d;
    logic [DATA_DEPTH_EXP2-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]      mem_q [DEPTH];
    logic [DATA_DEPTH_EXP2-1:0] wa;
    logic                       wr_en;

    assign ready_o = (state_q == ST_RUN);
    assign wa      = waddr_i[DATA_DEPTH_EXP2-1:0];
    assign wr_en   = ready_o && we_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (flush_i) begin
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == CNT_LAST) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // NOTE: the array has no reset; the sweep is what makes its contents defined.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (we_i) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (wstrb_i[k]) mem_q[wa][k*8 +: 8] <= wdata_i[k*8 +: 8];
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [DATA_DEPTH_EXP2-1:0] ra;
        logic [DATA_WIDTH-1:0]      rd_word;
        logic [DATA_WIDTH-1:0]      rdata_d, rdata_q;

        assign ra = raddr_i[p*ADDR_WIDTH +: DATA_DEPTH_EXP2];

`ifdef LUTRAM_WR_BYPASS_EN
        // Merge strobed lanes of an accepted write into a same-address read.
        always_comb begin
            rd_word = mem_q[ra];
            if (wr_en && (wa == ra)) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (wstrb_i[k]) rd_word[k*8 +: 8] = wdata_i[k*8 +: 8];
                end
            end
        end
`else
        assign rd_word = mem_q[ra];
`endif

        assign rdata_d = (ready_o && re_i[p]) ? rd_word : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rdata_q <= '0;
            else        rdata_q <= rdata_d;
        end

        assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    end

`ifndef LUTRAM_WR_BYPASS_EN
    logic unused_wr_en;
    assign unused_wr_en = wr_en;
`endif

endmodule

// File: tb/tb_multi_port_lutram_clr.sv
// Bench for multi_port_lutram_clr: 16 x 128-bit, two read ports, array-level model
// compared every cycle plus hand-computed literal expectations.
module tb_multi_port_lutram_clr;

    localparam int DW = 128;
    localparam int AW = 4;
    localparam int NP = 2;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            ready_o;
    logic            we;
    logic [DW/8-1:0] wstrb;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [NP-1:0]   re;
    logic [NP*AW-1:0] raddr;
    logic [NP*DW-1:0] rdata_o;

    int errors = 0;
    int checks = 0;

    localparam logic [DW-1:0] ONES  = '1;
    localparam logic [DW-1:0] PAT   = 128'h11223344_55667788_99AABBCC_DDEEF011;
    localparam logic [DW-1:0] STRB5 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFF011;

    multi_port_lutram_clr #(
        .DATA_WIDTH(DW), .DATA_DEPTH_EXP2(AW), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .ready_o(ready_o),
        .we_i(we), .wstrb_i(wstrb), .waddr_i(waddr), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] port_data(input int p);
        return rdata_o[p*DW +: DW];
    endfunction

    // Array-level model: writes land when ready, the whole array reads as zero once a sweep completes.
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] exp_rdata [NP];
    logic          exp_ready = 1'b0;
    int            sweep_left = DEPTH;

    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        for (int p = 0; p < NP; p++) exp_rdata[p] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_ready  = 1'b0;
                sweep_left = DEPTH;
                for (int p = 0; p < NP; p++) exp_rdata[p] = '0;
            end else begin
                logic old_ready;
                old_ready = exp_ready;
                for (int p = 0; p < NP; p++) begin
                    logic [DW-1:0] v;
                    int ra;
                    ra = int'(raddr[p*AW +: AW]);
                    v  = mm[ra];
`ifdef LUTRAM_WR_BYPASS_EN
                    if (old_ready && we && int'(waddr) == ra)
                        for (int k = 0; k < DW/8; k++)
                            if (wstrb[k]) v[k*8 +: 8] = wdata[k*8 +: 8];
`endif
                    exp_rdata[p] = (old_ready && re[p]) ? v : '0;
                end
                if (old_ready) begin
                    if (we)
                        for (int k = 0; k < DW/8; k++)
                            if (wstrb[k]) mm[waddr][k*8 +: 8] = wdata[k*8 +: 8];
                    if (flush) begin
                        exp_ready  = 1'b0;
                        sweep_left = DEPTH;
                    end
                end else if (flush) begin
                    sweep_left = DEPTH;
                end else begin
                    sweep_left--;
                    if (sweep_left == 0) begin
                        exp_ready = 1'b1;
                        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model ready_o", {{(DW-1){1'b0}}, ready_o}, {{(DW-1){1'b0}}, exp_ready});
            for (int p = 0; p < NP; p++)
                check($sformatf("model rdata_o[%0d]", p), port_data(p), exp_rdata[p]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW/8-1:0] s, input logic [DW-1:0] d);
        we = 1'b1; waddr = a[AW-1:0]; wstrb = s; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        re[p] = 1'b1;
        raddr[p*AW +: AW] = a[AW-1:0];
    endtask

    // ready_o stays low for 15 edges and rises on the 16th.
    task automatic sweep_check(input string name);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            check($sformatf("%s ready low edge %0d", name, i), {{(DW-1){1'b0}}, ready_o}, '0);
        end
        step();
        check($sformatf("%s ready high edge 16", name), {{(DW-1){1'b0}}, ready_o}, 1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; we = 1'b0; wstrb = '0; waddr = '0; wdata = '0;
        re = '0; raddr = '0;
        #12;
        check("reset ready_o", {{(DW-1){1'b0}}, ready_o}, '0);
        check("reset rdata0", port_data(0), '0);
        check("reset rdata1", port_data(1), '0);

        // Sweep after reset, with a write held on addr 3 the whole time.
        @(posedge clk); #1;
        rst_n = 1'b1;
        we = 1'b1; waddr = 4'd3; wstrb = '1; wdata = ONES;
        sweep_check("reset sweep");
        we = 1'b0;
        set_rd(0, 3); set_rd(1, 3);
        step();
        check("dropped write addr3 p0", port_data(0), '0);
        check("dropped write addr3 p1", port_data(1), '0);
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(0, i); set_rd(1, DEPTH - 1 - i);
            step();
        end
        re = '0;

        // Byte strobes.
        wr(5, '1, ONES);
        wr(5, 16'h0003, PAT);
        set_rd(0, 5);
        step();
        check("strobe addr5", port_data(0), STRB5);
        re = '0;
        wr(5, '0, '0);
        set_rd(1, 5);
        step();
        check("zero strobe no-op", port_data(1), STRB5);
        re = '0;

        // Multi-port read.
        wr(1, '1, 128'hA);
        wr(2, '1, 128'hB);
        set_rd(0, 1); set_rd(1, 2);
        step();
        check("mp rdata0", port_data(0), 128'hA);
        check("mp rdata1", port_data(1), 128'hB);
        re = '0;
        step();
        check("re off rdata0", port_data(0), '0);
        check("re off rdata1", port_data(1), '0);
        set_rd(0, 2); set_rd(1, 2);
        step();
        check("same addr p0", port_data(0), 128'hB);
        check("same addr p1", port_data(1), 128'hB);
        re = '0;

        // Collision on addr 7 (holds zero).
        set_rd(0, 7);
        we = 1'b1; waddr = 4'd7; wstrb = '1; wdata = 128'h55;
        step();
        we = 1'b0;
`ifdef LUTRAM_WR_BYPASS_EN
        check("collision full", port_data(0), 128'h55);
`else
        check("collision full", port_data(0), '0);
`endif
        step();
        check("collision reread", port_data(0), 128'h55);
        set_rd(1, 7);
        we = 1'b1; waddr = 4'd7; wstrb = 16'h0002; wdata = 128'hAAAA;
        step();
        we = 1'b0;
`ifdef LUTRAM_WR_BYPASS_EN
        check("collision partial", port_data(1), 128'hAA55);
`else
        check("collision partial", port_data(1), 128'h55);
`endif
        step();
        check("partial reread", port_data(1), 128'hAA55);
        re = '0;

        // Fill, then write and flush together.
        for (int i = 0; i < DEPTH - 1; i++) wr(i, '1, {8{16'(i + 1)}});
        we = 1'b1; waddr = 4'd15; wstrb = '1; wdata = ONES; flush = 1'b1;
        step();
        we = 1'b0; flush = 1'b0;
        check("flush ready low", {{(DW-1){1'b0}}, ready_o}, '0);
        sweep_check("flush sweep");
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(0, i); set_rd(1, i);
            step();
        end
        check("post flush addr15", port_data(0), '0);
        re = '0;

        // Flush mid-sweep restarts the sweep.
        flush = 1'b1; step(); flush = 1'b0;
        repeat (5) step();
        flush = 1'b1; step(); flush = 1'b0;
        sweep_check("mid flush sweep");

        // Flush on the final clear edge.
        flush = 1'b1; step(); flush = 1'b0;
        repeat (DEPTH - 1) step();
        flush = 1'b1; step(); flush = 1'b0;
        check("final edge flush ready", {{(DW-1){1'b0}}, ready_o}, '0);
        sweep_check("final edge sweep");

        // Asynchronous reset during a read.
        wr(9, '1, 128'hDEAD_BEEF);
        set_rd(0, 9);
        step();
        check("pre reset read", port_data(0), 128'hDEAD_BEEF);
        #1;
        rst_n = 1'b0;
        #1;
        check("async ready_o", {{(DW-1){1'b0}}, ready_o}, '0);
        check("async rdata0", port_data(0), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_check("post reset sweep");
        step();
        check("addr9 after sweep", port_data(0), '0);
        re = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
